// File: rtl/mac_dot_sched.sv
`default_nettype none
// ============================================================================
// Module      : mac_dot_sched
// Description : Drives a 3-cycle int8 multiply-add slice with three
//               interleaved partial sums, then reduces them to one dot product.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_dot_sched #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       pixel_in,
    input  logic [7:0]       weight_in,
    output logic             dsp_en,
    output logic [7:0]       dsp_pixel,
    output logic [7:0]       dsp_weight,
    output logic [31:0]      dsp_acc,
    input  logic [31:0]      dsp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data
);

    localparam logic [1:0]       c_ST_IDLE   = 2'd0;
    localparam logic [1:0]       c_ST_ACC    = 2'd1;
    localparam logic [1:0]       c_ST_DRAIN  = 2'd2;
    localparam logic [1:0]       c_ST_OUT    = 2'd3;
    localparam logic [LEN_W-1:0] c_ONE       = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_SLOTS     = LEN_W'(3);
    localparam logic [LEN_W:0]   c_DRAIN_MIN = (LEN_W+1)'(3);

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [1:0]       r_drain;
    logic [31:0]      r_sum;

    logic             w_beat;
    logic             w_last;
    logic [LEN_W:0]   w_drain_pos;
    logic             w_drain_keep;

    assign w_beat       = (r_state == c_ST_ACC) && in_valid;
    assign w_last       = (r_cnt == r_len - c_ONE);
    // Drain slot d holds the chain ending at issue N-3+d; negative means the
    // slot never received an issue this job and carries stale slice data.
    assign w_drain_pos  = {1'b0, r_len} + {{(LEN_W-1){1'b0}}, r_drain};
    assign w_drain_keep = (w_drain_pos >= c_DRAIN_MIN);

    assign busy      = (r_state != c_ST_IDLE);
    assign in_ready  = (r_state == c_ST_ACC);
    assign out_valid = (r_state == c_ST_OUT);
    assign out_data  = r_sum;

    always_comb begin
        dsp_en     = 1'b0;
        dsp_pixel  = 8'd0;
        dsp_weight = 8'd0;
        dsp_acc    = 32'd0;
        case (r_state)
            c_ST_ACC: begin
                if (in_valid) begin
                    dsp_en     = 1'b1;
                    dsp_pixel  = pixel_in;
                    dsp_weight = weight_in;
                    // First issue of each of the three slots starts from zero
                    dsp_acc    = (r_cnt < c_SLOTS) ? 32'd0 : dsp_data;
                end
            end
            c_ST_DRAIN: dsp_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_drain <= 2'd0;
            r_sum   <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_len   <= cfg_len;
                        r_cnt   <= '0;
                        r_drain <= 2'd0;
                        r_sum   <= 32'd0;
                        r_state <= (cfg_len == '0) ? c_ST_OUT : c_ST_ACC;
                    end
                end
                c_ST_ACC: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + c_ONE;
                        if (w_last) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_drain_keep) begin
                        r_sum <= r_sum + dsp_data;
                    end
                    r_drain <= r_drain + 2'd1;
                    if (r_drain == 2'd2) begin
                        r_state <= c_ST_OUT;
                    end
                end
                c_ST_OUT: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mac_dot_sched.md
# mac_dot_sched

Sequencing controller for the single int8 multiply-add DSP slice (P = A*B + C, 3 enabled-cycle latency, clock-enable gated). It accepts a stream of pixel/weight pairs and drives them into the slice, feeding P back into C. Three interleaved partial sums hide the feedback latency, so the block sustains one product per cycle. It then drains the slice, reduces the three partials in fabric and presents one 32-bit dot-product result per job. It sits between the line-buffer/weight fetch logic and the output requantisation stage of a conv PE.

## Interface
- LEN_W, 16, width of the per-job product count
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  job request; honoured only in IDLE
- cfg_len  in  LEN_W  number of products N, sampled on the accepted start
- busy  out  1  high from the cycle after the accepted start until the output handshake completes
- in_valid  in  1  operand pair valid
- in_ready  out  1  high only in ACC
- pixel_in  in  8  operand A
- weight_in  in  8  operand B
- dsp_en  out  1  slice clock enable
- dsp_pixel  out  8  to slice A
- dsp_weight  out  8  to slice B
- dsp_acc  out  32  to slice C
- dsp_data  in  32  slice P[31:0]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  32  dot product, modulo 2^32

## Operation
- Reset values: state IDLE; busy, in_ready, dsp_en, out_valid = 0; dsp_pixel, dsp_weight, dsp_acc, out_data = 0; issue counter and sum = 0.
- Slice contract: the dsp_data value sampled in the k-th enabled cycle is the result of the issue made in enabled cycle k-3. Disabled cycles freeze the slice and do not count.
- States:
  - IDLE: wait for start. On start, latch N, clear the issue counter i and sum. If N=0, go to OUT with sum=0; otherwise go to ACC.
  - ACC: in_ready=1. Each accepted beat (in_valid & in_ready) sets dsp_en=1, dsp_pixel=pixel_in and dsp_weight=weight_in, all combinational from the inputs. dsp_acc = 0 if i<3, else dsp_data. Then i++. With no accepted beat, dsp_en=0 and the slice holds, so slot alignment survives stalls. After the beat with i=N-1, go to DRAIN.
  - DRAIN: exactly 3 cycles, d=0,1,2. dsp_en=1, dsp_pixel=dsp_weight=0, dsp_acc=0. Each cycle sum += dsp_data, masked to 0 when N-3+d<0 (N<3). After d=2, go to OUT.
  - OUT: out_valid=1, out_data=sum held stable. On out_ready, go to IDLE.
- The slice pipeline is never cleared by this block. Stale contents, including after a reset mid-job, are excluded by two rules: acc=0 for the first 3 issues, and the drain mask.
- Arithmetic: 32-bit two's-complement wrap for both the feedback and the 3-way sum. Operand signedness is the slice's configuration; the block passes raw bits.
- start outside IDLE is ignored. cfg_len changes after the start is accepted have no effect.
- in_valid outside ACC is not consumed. in_ready is low, so producers must hold their data.

## Timing
- Start accepted at edge t: ACC (in_ready=1) from cycle t+1.
- With no stalls, beats are accepted at t+1..t+N, DRAIN runs t+N+1..t+N+3, and out_valid rises at t+N+4. Start-to-result latency is N+4 cycles; each input stall adds one.
- N=0: out_valid at t+1 with out_data=0; no dsp_en pulses.
- Throughput is 1 product/cycle in ACC. There is a 5-cycle per-job overhead (1 start, 3 drain, 1 output handshake minimum).
- out_valid holds until out_ready. The earliest next start is the cycle after the handshake.
- rst takes effect immediately at any point and returns all outputs to their reset values.

## Test plan
- Bench uses a behavioural slice model: 3-enabled-cycle pipeline, P=A*B+C, with random initial contents.
- N=4, pixels 1,2,3,4, weights 5,6,7,8, no stalls -> out_data=70; out_valid at start+8; exactly 7 dsp_en cycles.
- Same data with in_valid low for 2 cycles after beats 1 and 3 -> out_data=70; out_valid 4 cycles later; dsp_en low during the stalls.
- N=1 (3*4) -> 12. N=2 (3*4, 2*2) -> 16. N=0 -> 0 at start+1 with no dsp_en.
- out_ready low for 5 cycles in OUT -> out_valid and out_data stable; start pulses in that window ignored; busy stays high.
- Assert rst mid-ACC of a job at N=6, then run a fresh N=4 job -> 70; all outputs read reset values during rst.
- N=300, random operands, back-to-back jobs with random stalls and backpressure -> every result matches the reference model modulo 2^32.
